mips_trace_buffer: RTL and testbench

Execution-trace capture buffer that sits directly downstream of the MIPS SoC top and consumes its `pc_out` and `alu_result_out` observation outputs. On every qualified cycle it stores a 64-bit record `{pc, alu_result}` in a circular FIFO. It drains the records over a valid/ready stream to a debug transport (UART/JTAG bridge). Overflow never stalls the CPU; excess samples are dropped and counted.

---
 rtl/mips_trace_buffer_if.sv | 10 +
 rtl/mips_trace_buffer.sv | 115 +++++++++++
 tb/tb_mips_trace_buffer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mips_trace_buffer_if.sv
// Trace record stream between the capture buffer and the debug transport.
// master = trace buffer (drives record + valid), slave = consumer (drives ready).
interface mips_trace_buffer_if;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/mips_trace_buffer.sv
// Execution-trace capture FIFO: stores {pc, alu_result} records on qualified
// cycles and drains them over a valid/ready stream. Overflow never stalls the
// producer; excess samples are dropped and counted (saturating).
// Optional feature: define TRACE_DEDUP_EN to suppress repeated PCs (stalls).
module mips_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          pc_in,
  input  logic [31:0]          alu_in,
  input  logic                 capture_en,
  input  logic                 clear,
  mips_trace_buffer_if.master  strm,
  output logic [AW:0]          count,
  output logic                 full,
  output logic                 empty,
  output logic [15:0]          drop_count
);

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic [15:0]   drop_q, drop_d;

  logic dedup_ok, qual, pop, push, drop;

  assign qual = capture_en && !clear && dedup_ok;
  assign pop  = !empty_q && strm.out_ready;
  assign push = qual && (!full_q || pop);
  assign drop = qual && full_q && !pop;

`ifdef TRACE_DEDUP_EN
  logic [31:0] last_pc_q;
  logic        last_vld_q;

  assign dedup_ok = !last_vld_q || (pc_in != last_pc_q);

  // Remember the PC of every qualified sample, accepted or dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_pc_q  <= '0;
      last_vld_q <= 1'b0;
    end else if (clear) begin
      last_vld_q <= 1'b0;
    end else if (qual) begin
      last_pc_q  <= pc_in;
      last_vld_q <= 1'b1;
    end
  end
`else
  assign dedup_ok = 1'b1;
`endif

  // Next-state for pointers and status; clear overrides push, pop and drop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    full_d   = full_q;
    empty_d  = empty_q;
    drop_d   = drop_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      full_d   = 1'b0;
      empty_d  = 1'b1;
      drop_d   = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
      full_d  = (count_d == (AW+1)'(DEPTH));
      empty_d = (count_d == '0);
      if (drop && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end
  end

  // Status and pointer registers; reset empties the FIFO immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      drop_q   <= drop_d;
    end
  end

  // Record storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {pc_in, alu_in};
  end

  assign strm.out_valid = !empty_q;
  assign strm.out_data  = empty_q ? 64'h0 : mem_q[rd_ptr_q];
  assign count          = count_q;
  assign full           = full_q;
  assign empty          = empty_q;
  assign drop_count     = drop_q;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Directed bench for mips_trace_buffer (DEPTH=16).
module tb_mips_trace_buffer;
  logic        clk;
  logic        reset;
  logic [31:0] pc_in, alu_in;
  logic        capture_en, clear;
  logic [4:0]  count;
  logic        full, empty;
  logic [15:0] drop_count;
  int          total, bad;

  mips_trace_buffer_if s();

  mips_trace_buffer #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .alu_in(alu_in),
    .capture_en(capture_en), .clear(clear), .strm(s),
    .count(count), .full(full), .empty(empty), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rec(input logic [31:0] pc, input logic [31:0] alu);
    return {pc, alu};
  endfunction

  initial begin
    total = 0; bad = 0;
    reset = 1'b0; pc_in = '0; alu_in = '0;
    capture_en = 1'b0; clear = 1'b0; s.out_ready = 1'b0;
    step(); step();
    chk("rst_valid", 64'(s.out_valid), 64'd0);
    chk("rst_data", s.out_data, 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_drop", 64'(drop_count), 64'd0);
    reset = 1'b1;
    step();

    // single sample, 1-cycle latency
    capture_en = 1'b1; pc_in = 32'h0040_0000; alu_in = 32'h0000_0005;
    step();
    capture_en = 1'b0;
    chk("single_valid", 64'(s.out_valid), 64'd1);
    chk("single_data", s.out_data, 64'h0040_0000_0000_0005);
    chk("single_count", 64'(count), 64'd1);
    chk("single_empty", 64'(empty), 64'd0);
    s.out_ready = 1'b1;
    step();
    s.out_ready = 1'b0;
    chk("single_drained", 64'(empty), 64'd1);

    // fill with 20 distinct PCs, no drain
    capture_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      pc_in = 32'h1000 + 32'(4*i); alu_in = 32'(i) ^ 32'hA5A5;
      step();
      if (i == 15) begin
        chk("fill16_count", 64'(count), 64'd16);
        chk("fill16_full", 64'(full), 64'd1);
        chk("fill16_drop", 64'(drop_count), 64'd0);
      end
    end
    capture_en = 1'b0;
    chk("ovf_full", 64'(full), 64'd1);
    chk("ovf_count", 64'(count), 64'd16);
    chk("ovf_drop", 64'(drop_count), 64'd4);

    // full: simultaneous push and pop
    capture_en = 1'b1; s.out_ready = 1'b1;
    pc_in = 32'hBEEF_0000; alu_in = 32'h77;
    chk("pp_head", s.out_data, rec(32'h1000, 32'hA5A5));
    step();
    capture_en = 1'b0; s.out_ready = 1'b0;
    chk("pp_count", 64'(count), 64'd16);
    chk("pp_drop", 64'(drop_count), 64'd4);
    chk("pp_full", 64'(full), 64'd1);

    // drain: PCs 1..15 in order, then the wrapped-in record
    s.out_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("drain_%0d", i), s.out_data,
          rec(32'h1000 + 32'(4*i), 32'(i) ^ 32'hA5A5));
      step();
    end
    chk("drain_last", s.out_data, rec(32'hBEEF_0000, 32'h77));
    step();
    s.out_ready = 1'b0;
    chk("drain_empty", 64'(empty), 64'd1);
    chk("drain_data0", s.out_data, 64'd0);
    chk("drain_valid", 64'(s.out_valid), 64'd0);

    // dedup: same PC for 3 cycles then a new one
    capture_en = 1'b1; alu_in = 32'h1;
    pc_in = 32'h100; step(); step(); step();
    pc_in = 32'h104; step();
    capture_en = 1'b0;
`ifdef TRACE_DEDUP_EN
    chk("dedup_count", 64'(count), 64'd2);
`else
    chk("dedup_count", 64'(count), 64'd4);
`endif

    // clear priority: 5 stored, drop_count=3, clear with push and pop
    clear = 1'b1; step(); clear = 1'b0;
    chk("clr0_count", 64'(count), 64'd0);
    capture_en = 1'b1;
    for (int i = 0; i < 19; i++) begin
      pc_in = 32'h2000 + 32'(4*i); alu_in = 32'(i);
      step();
    end
    capture_en = 1'b0; s.out_ready = 1'b1;
    for (int i = 0; i < 11; i++) step();
    s.out_ready = 1'b0;
    chk("pre_clr_count", 64'(count), 64'd5);
    chk("pre_clr_drop", 64'(drop_count), 64'd3);
    clear = 1'b1; capture_en = 1'b1; s.out_ready = 1'b1;
    pc_in = 32'hDEAD_0000; alu_in = 32'h9;
    step();
    clear = 1'b0; capture_en = 1'b0; s.out_ready = 1'b0;
    chk("clr_count", 64'(count), 64'd0);
    chk("clr_empty", 64'(empty), 64'd1);
    chk("clr_drop", 64'(drop_count), 64'd0);
    chk("clr_data", s.out_data, 64'd0);

    // asynchronous reset while holding 7 entries
    capture_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      pc_in = 32'h3000 + 32'(4*i); alu_in = 32'(i);
      step();
    end
    capture_en = 1'b0;
    chk("ar_pre_count", 64'(count), 64'd7);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_valid", 64'(s.out_valid), 64'd0);
    chk("ar_count", 64'(count), 64'd0);
    chk("ar_empty", 64'(empty), 64'd1);
    step();
    reset = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
